// File: rtl/return_address_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : return_address_stack_pkg
// Brief   : Shared CPU constants, PC-source encodings and RAS operation codes.
// Revision: 1.0 - initial release
// ============================================================================
package return_address_stack_pkg;

  localparam int c_ras_depth = 8;
  localparam int c_ras_aw    = 32;

  // PC source select driven by the control unit into pcModule
  typedef enum logic [1:0] {
    PC_SRC_DFT = 2'd0,
    PC_SRC_RA  = 2'd1,
    PC_SRC_JMP = 2'd2,
    PC_SRC_BTA = 2'd3
  } pc_src_e;

  // One resolved stack action per clock edge
  typedef enum logic [2:0] {
    RAS_NOP          = 3'd0,
    RAS_REPLACE      = 3'd1,
    RAS_PUSH_ON_EMPTY = 3'd2,
    RAS_PUSH_REJECT  = 3'd3,
    RAS_PUSH         = 3'd4,
    RAS_POP_REJECT   = 3'd5,
    RAS_POP          = 3'd6
  } ras_op_e;

  function automatic int ras_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/return_address_stack_if.sv
`default_nettype none
// ============================================================================
// Module  : return_address_stack_if
// Brief   : Call/return request and top-of-stack status bundle for the RAS.
// Revision: 1.0 - initial release
// ============================================================================
interface return_address_stack_if
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = c_ras_depth,
  parameter int AW    = c_ras_aw
);

  localparam int c_cw = ras_count_width(DEPTH);

  logic            push;
  logic [AW-1:0]   pushAddress;
  logic            pop;
  logic            clearErr;
  logic [AW-1:0]   returnAddress;
  logic [c_cw-1:0] count;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;

  modport master (
    output push, pushAddress, pop, clearErr,
    input  returnAddress, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pushAddress, pop, clearErr,
    output returnAddress, count, empty, full, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
// Module  : return_address_stack
// Brief   : Return-address stack with sticky overflow/underflow; top-of-stack
//           is shown combinationally from registers for pcModule.
// Revision: 1.0 - initial release
// ============================================================================
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = c_ras_depth,
  parameter int AW    = c_ras_aw
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  return_address_stack_if.slave bus
);

  localparam int c_aiw = $clog2(DEPTH);
  localparam int c_cw  = ras_count_width(DEPTH);

  logic [AW-1:0]    r_entry [DEPTH];
  logic [c_cw-1:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [c_aiw-1:0] w_top_idx;
  logic [c_aiw-1:0] w_next_idx;
  ras_op_e          w_op;
  logic             w_wr_en;
  logic [c_aiw-1:0] w_wr_idx;
  logic [c_cw-1:0]  w_count_nxt;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_cw'(DEPTH));
  assign w_top_idx  = c_aiw'(r_count - c_cw'(1));
  assign w_next_idx = c_aiw'(r_count);

  // Resolve the request into exactly one action, pop/push priority included
  always_comb begin
    w_op = RAS_NOP;
    if (bus.push && bus.pop) begin
      w_op = w_empty ? RAS_PUSH_ON_EMPTY : RAS_REPLACE;
    end else if (bus.push) begin
      w_op = w_full ? RAS_PUSH_REJECT : RAS_PUSH;
    end else if (bus.pop) begin
      w_op = w_empty ? RAS_POP_REJECT : RAS_POP;
    end
  end

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = w_next_idx;
    w_count_nxt = r_count;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    unique case (w_op)
      RAS_REPLACE: begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_top_idx;
      end
      RAS_PUSH_ON_EMPTY: begin
        w_wr_en     = 1'b1;
        w_wr_idx    = '0;
        w_count_nxt = c_cw'(1);
        w_unf_evt   = 1'b1;
      end
      RAS_PUSH_REJECT: w_ovf_evt = 1'b1;
      RAS_PUSH: begin
        w_wr_en     = 1'b1;
        w_count_nxt = r_count + c_cw'(1);
      end
      RAS_POP_REJECT: w_unf_evt = 1'b1;
      // Vacated entry keeps its stale value; it is masked by the count
      RAS_POP: w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_entry[w_wr_idx] <= bus.pushAddress;
    end
  end

  // A new error event outranks a simultaneous clearErr
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= w_ovf_evt | (r_overflow  & ~bus.clearErr);
      r_underflow <= w_unf_evt | (r_underflow & ~bus.clearErr);
    end
  end

  assign bus.returnAddress = w_empty ? '0 : r_entry[w_top_idx];
  assign bus.count         = r_count;
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_address_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_return_address_stack
// Brief   : Scoreboard bench for return_address_stack against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_return_address_stack;
  import return_address_stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;

  typedef struct {
    string       tag;
    logic [31:0] ret;
    int          cnt;
    bit          emp;
    bit          ful;
    bit          ovf;
    bit          unf;
  } exp_t;

  logic    clk;
  logic    rst_n;
  pc_src_e pc_src;
  logic [31:0] pc;

  return_address_stack_if #(.DEPTH(DEPTH), .AW(AW)) ras_if ();

  return_address_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ras_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal pcModule stand-in: takes the RAS top when PC_SRC_RA is selected
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (pc_src == PC_SRC_RA) pc <= ras_if.returnAddress;
    else pc <= pc + 32'd1;
  end

  logic [31:0] m_stk[$];
  bit          m_ovf;
  bit          m_unf;
  exp_t        sb_q[$];
  int          n_total;
  int          n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit p, input logic [31:0] a, input bit q, input bit c);
    bit ov = 1'b0;
    bit un = 1'b0;
    int n  = m_stk.size();
    if (p && q) begin
      if (n > 0) m_stk[n-1] = a;
      else begin
        un = 1'b1;
        m_stk.push_back(a);
      end
    end else if (p) begin
      if (n == DEPTH) ov = 1'b1;
      else m_stk.push_back(a);
    end else if (q) begin
      if (n == 0) un = 1'b1;
      else void'(m_stk.pop_back());
    end
    m_ovf = ov | (m_ovf & !c);
    m_unf = un | (m_unf & !c);
  endtask

  function automatic exp_t model_expect(input string tag);
    exp_t e;
    e.tag = tag;
    e.cnt = m_stk.size();
    e.ret = (e.cnt > 0) ? m_stk[e.cnt-1] : 32'd0;
    e.emp = (e.cnt == 0);
    e.ful = (e.cnt == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  task automatic do_op(input bit p, input logic [31:0] a, input bit q, input bit c,
                       input string tag);
    @(negedge clk);
    ras_if.push        = p;
    ras_if.pushAddress = a;
    ras_if.pop         = q;
    ras_if.clearErr    = c;
    model_step(p, a, q, c);
    sb_q.push_back(model_expect(tag));
  endtask

  // Monitor: one expected response per clock edge, checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.tag, ".ret"}, 64'(ras_if.returnAddress), 64'(e.ret));
        chk({e.tag, ".count"}, 64'(ras_if.count), 64'(e.cnt));
        chk({e.tag, ".empty"}, 64'(ras_if.empty), 64'(e.emp));
        chk({e.tag, ".full"}, 64'(ras_if.full), 64'(e.ful));
        chk({e.tag, ".ovf"}, 64'(ras_if.overflow), 64'(e.ovf));
        chk({e.tag, ".unf"}, 64'(ras_if.underflow), 64'(e.unf));
      end
    end
  end

  initial begin
    int waited;
    bit p, q, c;
    n_total = 0;
    n_pass  = 0;
    pc_src  = PC_SRC_DFT;
    rst_n   = 1'b0;
    ras_if.push        = 1'b0;
    ras_if.pushAddress = '0;
    ras_if.pop         = 1'b0;
    ras_if.clearErr    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 64'(ras_if.count), 64'd0);
    chk("rst.empty", 64'(ras_if.empty), 64'd1);
    chk("rst.ret", 64'(ras_if.returnAddress), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a sequence
    do_op(1, 32'd5, 0, 0, "ar.push5");
    do_op(1, 32'd9, 0, 0, "ar.push9");
    do_op(1, 32'd13, 0, 0, "ar.push13");
    do_op(1, 32'd99, 1, 0, "ar.repl");
    do_op(0, 32'd0, 1, 1, "ar.pop");
    do_op(0, 32'd0, 0, 0, "ar.idle");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.count", 64'(ras_if.count), 64'd0);
    chk("ar.empty", 64'(ras_if.empty), 64'd1);
    chk("ar.ret", 64'(ras_if.returnAddress), 64'd0);
    chk("ar.flags", 64'({ras_if.overflow, ras_if.underflow}), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;

    // LIFO ordering
    do_op(1, 32'd5, 0, 0, "lifo.push5");
    do_op(1, 32'd9, 0, 0, "lifo.push9");
    do_op(1, 32'd13, 0, 0, "lifo.push13");
    do_op(0, 32'd0, 1, 0, "lifo.pop1");
    do_op(0, 32'd0, 1, 0, "lifo.pop2");
    do_op(0, 32'd0, 1, 0, "lifo.pop3");

    // Overflow at DEPTH
    for (int i = 1; i <= DEPTH; i++) do_op(1, 32'(i), 0, 0, "ovf.fill");
    do_op(1, 32'd99, 0, 0, "ovf.push99");
    do_op(0, 32'd0, 1, 0, "ovf.pop");
    for (int i = 0; i < DEPTH - 1; i++) do_op(0, 32'd0, 1, 0, "ovf.drain");

    // Underflow and clear-vs-error priority
    do_op(0, 32'd0, 1, 0, "unf.pop");
    do_op(0, 32'd0, 0, 1, "unf.clr");
    do_op(0, 32'd0, 1, 1, "unf.clrpop");
    do_op(0, 32'd0, 0, 1, "unf.clr2");

    // Simultaneous push and pop
    do_op(1, 32'd20, 0, 0, "pp.push20");
    do_op(1, 32'd40, 1, 0, "pp.repl40");
    do_op(0, 32'd0, 1, 0, "pp.pop");
    do_op(1, 32'd7, 1, 0, "pp.empty7");
    do_op(0, 32'd0, 1, 1, "pp.pop7");

    // Return through pcModule
    do_op(1, 32'd2, 0, 0, "pc.push2");
    pc_src = PC_SRC_RA;
    do_op(0, 32'd0, 1, 0, "pc.ret");
    @(posedge clk);
    #1;
    chk("pc.value", 64'(pc), 64'd2);
    pc_src = PC_SRC_DFT;

    // Randomized traffic: push-heavy phase then pop-heavy phase
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < ((i < 200) ? 60 : 30));
      q = ($urandom_range(0, 99) < ((i < 200) ? 30 : 60));
      c = ($urandom_range(0, 99) < 10);
      do_op(p, 32'($urandom), q, c, "rnd");
    end

    @(negedge clk);
    ras_if.push     = 1'b0;
    ras_if.pop      = 1'b0;
    ras_if.clearErr = 1'b0;
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
